// File: rtl/j80_pixel_rx_if.sv
// i8080 write-port pins plus the line-FIFO write side of j80_pixel_rx.
// master = MCU/FIFO environment, slave = the receiver.
interface j80_pixel_rx_if #(
    parameter int BUS_W = 8,
    parameter int PIX_W = 16
);
    logic             J80_CLK;
    logic             J80_RS;
    logic             J80_We;
    logic [BUS_W-1:0] J80_Data;
    logic             FIFO_Full;
    logic             FIFOWe;
    logic [PIX_W-1:0] FIFO_Data;

    modport master (
        output J80_CLK, J80_RS, J80_We, J80_Data, FIFO_Full,
        input  FIFOWe, FIFO_Data
    );

    modport slave (
        input  J80_CLK, J80_RS, J80_We, J80_Data, FIFO_Full,
        output FIFOWe, FIFO_Data
    );
endinterface

// File: rtl/j80_pixel_rx.sv
// i8080 write-port receiver: synchronises the strobe bus, decodes commands, packs pixels.
// Optional macro J80_DROPCNT_EN builds the saturating dropped-pixel counter (DropCnt=0 otherwise).
module j80_pixel_rx #(
    parameter int BUS_W       = 8,
    parameter int PIX_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    j80_pixel_rx_if.slave bus,
    output logic        LCD_BL,
    output logic        FrameCtrl,
    output logic        Ovf,
    output logic [15:0] DropCnt
);
    localparam int BEATS = PIX_W / BUS_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST  = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] rs_sync;
    logic [SYNC_STAGES-1:0] we_sync;
    logic [BUS_W-1:0]       data_sync [SYNC_STAGES];
    logic                   clk_prev;

    logic [BW-1:0]    beat;
    logic             swap;
    logic [PIX_W-1:0] acc;
    logic [PIX_W-1:0] word_next;
    logic [BW-1:0]    slot;
    logic             fifo_we;
    logic [PIX_W-1:0] fifo_data;

    logic             wr_ev;
    logic             cmd_ev;
    logic             pix_ev;
    logic             last_beat;
    logic [2:0]       op;
    logic             arg;
    logic [BUS_W-1:0] wr_data;

    // RS/We/Data ride the same chain depth as the strobe so they line up with its edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_sync <= '0;
            rs_sync  <= '0;
            we_sync  <= '0;
            clk_prev <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
        end else begin
            clk_sync     <= {clk_sync[SYNC_STAGES-2:0], bus.J80_CLK};
            rs_sync      <= {rs_sync[SYNC_STAGES-2:0], bus.J80_RS};
            we_sync      <= {we_sync[SYNC_STAGES-2:0], bus.J80_We};
            clk_prev     <= clk_sync[LAST];
            data_sync[0] <= bus.J80_Data;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
        end
    end

    always_comb begin
        wr_ev     = clk_sync[LAST] & ~clk_prev & we_sync[LAST];
        cmd_ev    = wr_ev & rs_sync[LAST];
        pix_ev    = wr_ev & ~rs_sync[LAST];
        wr_data   = data_sync[LAST];
        op        = wr_data[BUS_W-1 -: 3];
        arg       = wr_data[0];
        last_beat = (beat == BW'(BEATS - 1));
        slot      = swap ? beat : (BW'(BEATS - 1) - beat);
        word_next = acc;
        word_next[slot*BUS_W +: BUS_W] = wr_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            beat      <= '0;
            swap      <= 1'b0;
            acc       <= '0;
            fifo_we   <= 1'b0;
            fifo_data <= '0;
            LCD_BL    <= 1'b0;
            FrameCtrl <= 1'b0;
            Ovf       <= 1'b0;
        end else begin
            fifo_we <= 1'b0;
            if (cmd_ev) begin
                beat <= '0;
                case (op)
                    3'b001:  LCD_BL    <= arg;
                    3'b010:  FrameCtrl <= arg;
                    3'b011:  swap      <= arg;
                    3'b100:  Ovf       <= 1'b0;
                    default: ;
                endcase
            end else if (pix_ev) begin
                acc <= word_next;
                if (last_beat) begin
                    beat <= '0;
                    // FIFO_Full is only looked at here; a full FIFO loses the whole pixel.
                    if (!bus.FIFO_Full) begin
                        fifo_we   <= 1'b1;
                        fifo_data <= word_next;
                    end else begin
                        Ovf <= 1'b1;
                    end
                end else begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end

    assign bus.FIFOWe    = fifo_we;
    assign bus.FIFO_Data = fifo_data;

`ifdef J80_DROPCNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_cnt <= '0;
        end else if (cmd_ev && op == 3'b100) begin
            drop_cnt <= '0;
        end else if (pix_ev && last_beat && bus.FIFO_Full && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign DropCnt = drop_cnt;
`else
    assign DropCnt = 16'h0;
`endif
endmodule

// File: tb/tb_j80_pixel_rx.sv
// Randomised self-checking bench for j80_pixel_rx (8/16 and 16/16 instances) against a queue model.
module tb_j80_pixel_rx;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        bl0, fc0, ovf0, bl1, fc1, ovf1;
    logic [15:0] drop0, drop1;

    int checks = 0;
    int errors = 0;

    j80_pixel_rx_if #(.BUS_W(8),  .PIX_W(16)) j0 ();
    j80_pixel_rx_if #(.BUS_W(16), .PIX_W(16)) j1 ();

    j80_pixel_rx #(.BUS_W(8), .PIX_W(16), .SYNC_STAGES(2)) u0 (
        .CLK(CLK), .RST(RST), .bus(j0.slave),
        .LCD_BL(bl0), .FrameCtrl(fc0), .Ovf(ovf0), .DropCnt(drop0)
    );

    j80_pixel_rx #(.BUS_W(16), .PIX_W(16), .SYNC_STAGES(2)) u1 (
        .CLK(CLK), .RST(RST), .bus(j1.slave),
        .LCD_BL(bl1), .FrameCtrl(fc1), .Ovf(ovf1), .DropCnt(drop1)
    );

    always #5 CLK = ~CLK;

    logic [15:0] got0[$];
    logic [15:0] got1[$];
    always @(negedge CLK) begin
        if (j0.FIFOWe === 1'b1) got0.push_back(j0.FIFO_Data);
        if (j1.FIFOWe === 1'b1) got1.push_back(j1.FIFO_Data);
    end

    // reference model of the 8-bit instance
    bit          m_bl, m_fc, m_swap, m_ovf;
    int          m_drop;
    logic [7:0]  m_beats[$];
    logic [15:0] exp_q[$];

    function automatic logic [15:0] drop_exp();
`ifdef J80_DROPCNT_EN
        return 16'(m_drop);
`else
        return 16'h0;
`endif
    endfunction

    task automatic model_reset();
        m_bl = 0; m_fc = 0; m_swap = 0; m_ovf = 0; m_drop = 0;
        m_beats.delete();
    endtask

    task automatic model_write(input bit rs, input logic [7:0] d, input bit full);
        logic [15:0] word;
        if (rs) begin
            case (d[7:5])
                3'd1: m_bl = d[0];
                3'd2: m_fc = d[0];
                3'd3: m_swap = d[0];
                3'd4: begin m_ovf = 0; m_drop = 0; end
                default: ;
            endcase
            m_beats.delete();
        end else begin
            m_beats.push_back(d);
            if (m_beats.size() == 2) begin
                word = 0;
                for (int i = 0; i < 2; i++) begin
                    if (!m_swap) word = (word << 8) | 16'(m_beats[i]);
                    else         word = word | (16'(m_beats[i]) << (8 * i));
                end
                if (!full) exp_q.push_back(word);
                else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                m_beats.delete();
            end
        end
    endtask

    task automatic wr0(input bit rs, input logic [7:0] d, input bit full);
        @(negedge CLK);
        j0.J80_RS = rs; j0.J80_Data = d; j0.J80_We = 1'b1; j0.FIFO_Full = full;
        repeat (3) @(negedge CLK);
        j0.J80_CLK = 1'b1;
        repeat (3) @(negedge CLK);
        j0.J80_CLK = 1'b0;
        repeat (3) @(negedge CLK);
        model_write(rs, d, full);
    endtask

    task automatic wr1(input logic [15:0] d);
        @(negedge CLK);
        j1.J80_RS = 1'b0; j1.J80_Data = d; j1.J80_We = 1'b1; j1.FIFO_Full = 1'b0;
        repeat (3) @(negedge CLK);
        j1.J80_CLK = 1'b1;
        repeat (3) @(negedge CLK);
        j1.J80_CLK = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge CLK);
        RST = 1'b1;
        repeat (n) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        j0.J80_We = 1'b1; j0.J80_RS = 1'b0; j0.J80_Data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            j0.J80_CLK = ~j0.J80_CLK;
            @(negedge CLK);
        end
        j0.J80_CLK = 1'b0;
        RST = 1'b0;
        model_reset();
        repeat (8) @(negedge CLK);
        checks++;
        if ({bl0, fc0, ovf0} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {bl0, fc0, ovf0});
        end
        checks++;
        if (drop0 !== 16'h0 || j0.FIFO_Data !== 16'h0) begin
            errors++; $display("FAIL reset_data got drop %h data %h exp 0 0", drop0, j0.FIFO_Data);
        end
        checks++;
        if (got0.size() != 0 || j0.FIFOWe !== 1'b0) begin
            errors++; $display("FAIL reset_nowe got %0d pulses exp 0", got0.size());
        end
    endtask

    task automatic test_commands();
        wr0(1, 8'h20, 0);
        wr0(1, 8'h41, 0);
        checks++;
        if (bl0 !== 1'b0 || fc0 !== 1'b1) begin
            errors++; $display("FAIL cmd_fc got bl %b fc %b exp bl 0 fc 1", bl0, fc0);
        end
        wr0(1, 8'h21, 0);
        checks++;
        if (bl0 !== 1'b1 || fc0 !== 1'b1) begin
            errors++; $display("FAIL cmd_bl got bl %b fc %b exp bl 1 fc 1", bl0, fc0);
        end
        wr0(1, 8'hE1, 0);
        checks++;
        if (bl0 !== m_bl || fc0 !== m_fc) begin
            errors++; $display("FAIL cmd_ignored got bl %b fc %b exp %b %b", bl0, fc0, m_bl, m_fc);
        end
    endtask

    task automatic test_pixels();
        got0.delete(); exp_q.delete();
        wr0(0, 8'h60, 0);
        checks++;
        if (got0.size() != 0) begin
            errors++; $display("FAIL pix_half got %0d pulses exp 0", got0.size());
        end
        wr0(0, 8'h1F, 0);
        checks++;
        if (got0.size() != 1 || got0[0] !== 16'h601F) begin
            errors++; $display("FAIL pix_first got %0d pulses data %h exp 1 601f", got0.size(),
                               got0.size() > 0 ? got0[0] : 16'hx);
        end
        got0.delete(); exp_q.delete();
        for (int i = 0; i < 20; i++) wr0(0, 8'($urandom), 0);
        checks++;
        if (got0.size() != 10 || exp_q.size() != 10) begin
            errors++; $display("FAIL pix_twenty got %0d pulses exp 10", got0.size());
        end
        for (int i = 0; i < got0.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got0[i] !== exp_q[i]) begin
                errors++; $display("FAIL pix_word[%0d] got %h exp %h", i, got0[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_swap();
        got0.delete(); exp_q.delete();
        wr0(1, 8'h61, 0);
        wr0(0, 8'hAB, 0);
        wr0(0, 8'hCD, 0);
        checks++;
        if (got0.size() != 1 || got0[0] !== 16'hCDAB) begin
            errors++; $display("FAIL swap_word got %0d pulses data %h exp 1 cdab", got0.size(),
                               got0.size() > 0 ? got0[0] : 16'hx);
        end
        wr0(1, 8'h60, 0);
    endtask

    task automatic test_overflow();
        got0.delete(); exp_q.delete();
        wr0(0, 8'h11, 0);
        wr0(0, 8'h22, 1);
        checks++;
        if (got0.size() != 0 || ovf0 !== 1'b1 || drop0 !== drop_exp()) begin
            errors++; $display("FAIL ovf_drop got pulses %0d ovf %b drop %h exp 0 1 %h",
                               got0.size(), ovf0, drop0, drop_exp());
        end
        wr0(0, 8'h33, 0);
        wr0(0, 8'h44, 0);
        checks++;
        if (got0.size() != 1 || ovf0 !== 1'b1 || got0[0] !== 16'h3344) begin
            errors++; $display("FAIL ovf_sticky got pulses %0d ovf %b exp 1 1", got0.size(), ovf0);
        end
        wr0(1, 8'h80, 0);
        checks++;
        if (ovf0 !== 1'b0 || drop0 !== 16'h0) begin
            errors++; $display("FAIL ovf_clear got ovf %b drop %h exp 0 0", ovf0, drop0);
        end
    endtask

    task automatic test_partial();
        got0.delete(); exp_q.delete();
        wr0(0, 8'h12, 0);
        wr0(1, 8'h00, 0);
        wr0(0, 8'h34, 0);
        wr0(0, 8'h56, 0);
        checks++;
        if (got0.size() != 1 || got0[0] !== 16'h3456) begin
            errors++; $display("FAIL partial_cmd got %0d pulses data %h exp 1 3456", got0.size(),
                               got0.size() > 0 ? got0[0] : 16'hx);
        end
        wr0(1, 8'h21, 0);
        wr0(0, 8'h12, 0);
        pulse_reset(1);
        checks++;
        if (bl0 !== 1'b0 || j0.FIFO_Data !== 16'h0) begin
            errors++; $display("FAIL partial_rst_out got bl %b data %h exp 0 0", bl0, j0.FIFO_Data);
        end
        got0.delete(); exp_q.delete();
        wr0(0, 8'h34, 0);
        wr0(0, 8'h56, 0);
        checks++;
        if (got0.size() != 1 || got0[0] !== 16'h3456) begin
            errors++; $display("FAIL partial_rst got %0d pulses data %h exp 1 3456", got0.size(),
                               got0.size() > 0 ? got0[0] : 16'hx);
        end
    endtask

    task automatic test_wide();
        logic [15:0] sent[$];
        got1.delete();
        for (int i = 0; i < 6; i++) begin
            sent.push_back(16'($urandom));
            wr1(sent[i]);
        end
        checks++;
        if (got1.size() != 6) begin
            errors++; $display("FAIL wide_count got %0d pulses exp 6", got1.size());
        end
        for (int i = 0; i < got1.size() && i < 6; i++) begin
            checks++;
            if (got1[i] !== sent[i]) begin
                errors++; $display("FAIL wide_word[%0d] got %h exp %h", i, got1[i], sent[i]);
            end
        end
    endtask

    task automatic test_random();
        bit         rs, full;
        logic [7:0] d;
        got0.delete(); exp_q.delete();
        for (int i = 0; i < 150; i++) begin
            rs   = ($urandom_range(0, 4) == 0);
            d    = 8'($urandom);
            full = ($urandom_range(0, 5) == 0);
            wr0(rs, d, full);
            checks++;
            if (bl0 !== m_bl || fc0 !== m_fc || ovf0 !== m_ovf || drop0 !== drop_exp()) begin
                errors++;
                $display("FAIL rand_state[%0d] got bl %b fc %b ovf %b drop %h exp %b %b %b %h",
                         i, bl0, fc0, ovf0, drop0, m_bl, m_fc, m_ovf, drop_exp());
            end
        end
        checks++;
        if (got0.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d exp %0d", got0.size(), exp_q.size());
        end
        for (int i = 0; i < got0.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got0[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_word[%0d] got %h exp %h", i, got0[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout after 2 ms");
        $fatal(1);
    end

    initial begin
        j0.J80_CLK = 0; j0.J80_RS = 0; j0.J80_We = 0; j0.J80_Data = 0; j0.FIFO_Full = 0;
        j1.J80_CLK = 0; j1.J80_RS = 0; j1.J80_We = 0; j1.J80_Data = 0; j1.FIFO_Full = 0;
        model_reset();
        test_reset();
        test_commands();
        test_pixels();
        test_swap();
        test_overflow();
        test_partial();
        test_wide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
